// File: rtl/shift_store_reg.sv
// Universal WIDTH-bit shift register (hold/up/down/load) with storage stage, shift counter, tri-state q.
// Latency: sr/cnt/word_done update 1 cycle after the sampling edge; q lags st_load by 1 cycle.
// Backpressure: none; every clk edge is accepted, and n_oe gates only the q drivers.
//
// Ports:
//   clk        rising-edge clock
//   n_clr      async active-low reset of all state
//   n_srclr    sync active-low clear of sr and cnt (st_load still captures pre-clear sr)
//   mode       00 hold, 01 shift up, 10 shift down, 11 parallel load
//   ser_up     serial in to bit 0 on shift up
//   ser_dn     serial in to bit WIDTH-1 on shift down
//   d          parallel load data
//   st_load    copy sr into storage register
//   n_oe       active-low output enable for q
//   q          storage register (or sr when no storage stage), 'z when n_oe=1
//   co_up      sr[WIDTH-1], cascade to next stage's ser_up
//   co_dn      sr[0], cascade to previous stage's ser_dn
//   word_done  one-cycle pulse after WIDTH consecutive shifts
//
// Build option: define SHIFT_STORE_STAGE_EN to include the storage register;
// otherwise q follows sr directly and st_load is ignored.
module shift_store_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_clr,
  input  logic             n_srclr,
  input  logic [1:0]       mode,
  input  logic             ser_up,
  input  logic             ser_dn,
  input  logic [WIDTH-1:0] d,
  input  logic             st_load,
  input  logic             n_oe,
  output logic [WIDTH-1:0] q,
  output logic             co_up,
  output logic             co_dn,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DN   = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             word_done_nxt;
  logic             shift_en;
  logic             cnt_last;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);
  assign shift_en = (mode_sel == MODE_UP) || (mode_sel == MODE_DN);
  // Explicit terminal compare so non-power-of-two widths still wrap at WIDTH.
  assign cnt_last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    sr_nxt        = sr;
    cnt_nxt       = cnt;
    word_done_nxt = 1'b0;
    if (!n_srclr) begin
      sr_nxt  = '0;
      cnt_nxt = '0;
    end else begin
      case (mode_sel)
        MODE_UP:   sr_nxt = {sr[WIDTH-2:0], ser_up};
        MODE_DN:   sr_nxt = {ser_dn, sr[WIDTH-1:1]};
        MODE_LOAD: begin
          sr_nxt  = d;
          cnt_nxt = '0;
        end
        default:   sr_nxt = sr;
      endcase
      // Direction may change mid-word; any shift advances the same counter.
      if (shift_en) begin
        if (cnt_last) begin
          cnt_nxt       = '0;
          word_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      sr        <= '0;
      cnt       <= '0;
      word_done <= 1'b0;
    end else begin
      sr        <= sr_nxt;
      cnt       <= cnt_nxt;
      word_done <= word_done_nxt;
    end
  end

  assign co_up = sr[WIDTH-1];
  assign co_dn = sr[0];

`ifdef SHIFT_STORE_STAGE_EN
  logic [WIDTH-1:0] st;

  // Captures sr as it was before this edge, so a same-edge shift lags by one.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      st <= '0;
    end else if (st_load) begin
      st <= sr;
    end
  end

  assign q = n_oe ? {WIDTH{1'bz}} : st;
`else
  logic unused_st_load;
  assign unused_st_load = st_load;

  assign q = n_oe ? {WIDTH{1'bz}} : sr;
`endif

endmodule

// File: tb/tb_shift_store_reg.sv
// Directed bench for shift_store_reg (WIDTH=8): vector table plus reset/OE/word sequences.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: none; one vector applied per clock.
module tb_shift_store_reg;

  logic       clk;
  logic       n_clr;
  logic       n_srclr;
  logic [1:0] mode;
  logic       ser_up;
  logic       ser_dn;
  logic [7:0] d;
  logic       st_load;
  logic       n_oe;
  wire  [7:0] q;
  logic       co_up;
  logic       co_dn;
  logic       word_done;

  int checks = 0;
  int errors = 0;

  shift_store_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .n_clr     (n_clr),
    .n_srclr   (n_srclr),
    .mode      (mode),
    .ser_up    (ser_up),
    .ser_dn    (ser_dn),
    .d         (d),
    .st_load   (st_load),
    .n_oe      (n_oe),
    .q         (q),
    .co_up     (co_up),
    .co_dn     (co_dn),
    .word_done (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       n_srclr;
    logic [1:0] mode;
    logic       ser_up;
    logic       ser_dn;
    logic [7:0] d;
    logic       st_load;
    logic [7:0] q_st;   // expected q with storage stage
    logic [7:0] q_sr;   // expected q without storage stage (q == sr)
    logic       co_up;
    logic       co_dn;
    logic       wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic nsc, input logic [1:0] m, input logic su,
                             input logic sd, input logic [7:0] dd, input logic stl,
                             input logic [7:0] qst, input logic [7:0] qsr,
                             input logic cu, input logic cd, input logic w);
    vec_t r;
    r.n_srclr = nsc; r.mode = m; r.ser_up = su; r.ser_dn = sd; r.d = dd;
    r.st_load = stl; r.q_st = qst; r.q_sr = qsr; r.co_up = cu; r.co_dn = cd; r.wd = w;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pick_q(input logic [7:0] qst, input logic [7:0] qsr);
`ifdef SHIFT_STORE_STAGE_EN
    pick_q = qst;
`else
    pick_q = qsr;
`endif
  endfunction

  initial begin
    logic [7:0] su_pat;
    logic [7:0] sr_exp;
    logic [7:0] zz;
    zz = 8'hzz;

    // Stimulus table: sr goes 3C -> 0 -> B2 -> 81 -> 40 ... (hand-computed).
    tbl.push_back(v(1, 2'b11, 0, 0, 8'h3C, 1, 8'h00, 8'h3C, 0, 0, 0)); // load, store pre-load 0
    tbl.push_back(v(1, 2'b00, 0, 0, 8'h00, 1, 8'h3C, 8'h3C, 0, 0, 0)); // store 3C
    tbl.push_back(v(1, 2'b11, 0, 0, 8'h00, 0, 8'h3C, 8'h00, 0, 0, 0)); // load 0, cnt=0
    su_pat = 8'b0100_1101; // bit i is ser_up for shift i: 1,0,1,1,0,0,1,0
    sr_exp = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sr_exp = {sr_exp[6:0], su_pat[i]};
      tbl.push_back(v(1, 2'b01, su_pat[i], 0, 8'h00, 0, 8'h3C, sr_exp,
                      sr_exp[7], sr_exp[0], (i == 7)));
    end
    tbl.push_back(v(1, 2'b00, 0, 0, 8'h00, 1, 8'hB2, 8'hB2, 1, 0, 0)); // sr=B2, store it
    tbl.push_back(v(1, 2'b11, 0, 0, 8'h81, 0, 8'hB2, 8'h81, 1, 1, 0)); // load 81
    tbl.push_back(v(1, 2'b10, 0, 0, 8'h00, 1, 8'h81, 8'h40, 0, 0, 0)); // shift dn + store pre-shift
    tbl.push_back(v(1, 2'b01, 1, 0, 8'h00, 0, 8'h81, 8'h81, 1, 1, 0)); // direction change
    tbl.push_back(v(1, 2'b10, 0, 1, 8'h00, 0, 8'h81, 8'hC0, 1, 0, 0));
    tbl.push_back(v(1, 2'b10, 0, 0, 8'h00, 0, 8'h81, 8'h60, 0, 0, 0));
    tbl.push_back(v(1, 2'b10, 0, 0, 8'h00, 0, 8'h81, 8'h30, 0, 0, 0)); // 5 shifts since load
    tbl.push_back(v(0, 2'b01, 1, 0, 8'h00, 1, 8'h30, 8'h00, 0, 0, 0)); // clear wins, st gets 30
    sr_exp = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sr_exp = {sr_exp[6:0], 1'b1};
      tbl.push_back(v(1, 2'b01, 1, 0, 8'h00, 0, 8'h30, sr_exp, sr_exp[7], 1, (i == 7)));
    end
    tbl.push_back(v(1, 2'b00, 0, 0, 8'h00, 1, 8'hFF, 8'hFF, 1, 1, 0)); // hold, store FF
    for (int i = 0; i < 8; i++) begin
      sr_exp = {sr_exp[6:0], 1'b0};
      tbl.push_back(v(1, 2'b01, 0, 0, 8'h00, 0, 8'hFF, sr_exp, sr_exp[7], 0, (i == 7)));
    end
    tbl.push_back(v(1, 2'b00, 0, 0, 8'h00, 0, 8'hFF, 8'h00, 0, 0, 0));

    // Reset held across edges while loading A5: nothing may change.
    n_clr = 1'b0; n_srclr = 1'b1; mode = 2'b11; ser_up = 1'b0; ser_dn = 1'b0;
    d = 8'hA5; st_load = 1'b1; n_oe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset q", q, 8'h00);
    chk("reset co_up", {7'd0, co_up}, 8'h00);
    chk("reset co_dn", {7'd0, co_dn}, 8'h00);
    chk("reset word_done", {7'd0, word_done}, 8'h00);
    n_clr = 1'b1;

    foreach (tbl[i]) begin
      n_srclr = tbl[i].n_srclr; mode = tbl[i].mode; ser_up = tbl[i].ser_up;
      ser_dn = tbl[i].ser_dn; d = tbl[i].d; st_load = tbl[i].st_load;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d q", i), q, pick_q(tbl[i].q_st, tbl[i].q_sr));
      chk($sformatf("row%0d co_up", i), {7'd0, co_up}, {7'd0, tbl[i].co_up});
      chk($sformatf("row%0d co_dn", i), {7'd0, co_dn}, {7'd0, tbl[i].co_dn});
      chk($sformatf("row%0d word_done", i), {7'd0, word_done}, {7'd0, tbl[i].wd});
    end

    // Output enable: st=FF, sr=00. No clock edge between the two checks.
    n_oe = 1'b1;
    #1;
    chk("oe off q", q, zz);
    n_oe = 1'b0;
    #1;
    chk("oe on q", q, pick_q(8'hFF, 8'h00));

    // Async reset mid-word, then a full word must count from shift 1.
    mode = 2'b01; ser_up = 1'b1; st_load = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    n_clr = 1'b0;
    #1;
    chk("midreset co_dn", {7'd0, co_dn}, 8'h00);
    chk("midreset q", q, 8'h00);
    @(posedge clk);
    #1;
    chk("midreset hold co_dn", {7'd0, co_dn}, 8'h00);
    chk("midreset word_done", {7'd0, word_done}, 8'h00);
    #2;
    n_clr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-reset shift%0d word_done", i + 1), {7'd0, word_done},
          {7'd0, (i == 7)});
      chk($sformatf("post-reset shift%0d co_up", i + 1), {7'd0, co_up}, {7'd0, (i == 7)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_store_reg.md
# shift_store_reg

Parametrised universal shift register with an output storage stage, a shift counter and tri-state outputs. It generalises the discrete dual D flip-flop models into a WIDTH-bit chain of flip-flops with hold, bidirectional shift and parallel load, as in the 74HC194/74HC595 families. It sits in the logic-IC model library and serves the CPU datapath wherever serial-to-parallel or parallel-to-serial transfer and cascaded registers are needed.

## Interface
- WIDTH, 8: register width in bits; legal range is 2 to 32.
- clk  input  1  single clock; rising-edge active.
- n_clr  input  1  asynchronous, active-low reset.
- n_srclr  input  1  synchronous, active-low clear of the shift register and counter.
- mode  input  2  operation select: 00 hold, 01 shift up, 10 shift down, 11 parallel load.
- ser_up  input  1  serial input entering bit 0 on shift up.
- ser_dn  input  1  serial input entering bit WIDTH-1 on shift down.
- d  input  WIDTH  parallel load data.
- st_load  input  1  copy the shift register into the storage register.
- n_oe  input  1  active-low output enable for q.
- q  output  WIDTH  storage register value; 'z when n_oe=1.
- co_up  output  1  sr[WIDTH-1]; cascade into the next stage's ser_up.
- co_dn  output  1  sr[0]; cascade into the previous stage's ser_dn.
- word_done  output  1  one-cycle pulse after WIDTH consecutive shifts.

## Operation
- State:
  - sr[WIDTH-1:0] is the shift register.
  - st[WIDTH-1:0] is the storage register.
  - cnt, $clog2(WIDTH) bits, counts shifts.
  - word_done is a registered output.
- Reset (n_clr=0, asynchronous, dominates everything): sr=0, st=0, cnt=0, word_done=0. q=0 if n_oe=0. co_up=co_dn=0.
- Priority at each rising clk edge is n_srclr, then mode.
- n_srclr=0: sr<=0 and cnt<=0, regardless of mode. st_load is still honoured and captures the pre-clear sr.
- mode 00: sr and cnt hold.
- mode 01: sr <= {sr[WIDTH-2:0], ser_up}.
- mode 10: sr <= {ser_dn, sr[WIDTH-1:1]}.
- mode 11: sr <= d and cnt <= 0.
- Counter:
  - Each shift (mode 01 or 10) increments cnt modulo WIDTH.
  - The direction may change mid-word; cnt keeps counting.
  - When a shift occurs with cnt==WIDTH-1, cnt wraps to 0 and word_done <= 1 on the same edge. Otherwise word_done <= 0.
- Storage: st_load=1 gives st <= sr as it was before this edge. When st_load and a shift occur on the same edge, st receives the pre-shift value, so it lags by one shift.
- Outputs:
  - co_up and co_dn come combinationally from sr.
  - q is combinational from st and n_oe.
  - n_oe does not affect any internal state.

## Timing
- Shift, load and clear latency: 1 cycle from the sampling edge to the sr change. co_* are valid after the same edge.
- st_load: q changes one cycle after the edge that samples st_load, and reflects sr as it was before that edge.
- word_done is high for exactly the one cycle following the WIDTH-th shift edge. Back-to-back words give one pulse every WIDTH cycles.
- Deasserting n_clr mid-operation resumes from the all-zero state. The first shift after release counts as shift 1.
- X or Z on mode is not supported; the bench must not drive it.

## Configuration
- SHIFT_STORE_STAGE_EN defined: the storage register exists as described above.
- Not defined:
  - st is removed and st_load is ignored.
  - q follows sr directly, with 0-cycle latency from sr and the same n_oe gating.
  - The reset value of q is still 0 when n_oe=0.

## Test plan
- Reset: with n_clr=0 during mode=11 and d=8'hA5, sr stays 0. After release with n_oe=0 and st_load=1, q=8'h00 on the following cycle.
- Parallel load and storage: load d=8'h3C, then assert st_load for one cycle. q=8'h3C one cycle later. co_up=0 and co_dn=0.
- Shift up word: after a load of 0, shift up 8 times with ser_up pattern 1,0,1,1,0,0,1,0.
  - sr=8'hB2.
  - word_done pulses once, in the cycle after the 8th shift.
  - co_up follows bit 7.
- Shift down with simultaneous store: sr=8'h81. Shift down with ser_dn=0 and st_load=1 on the same edge. sr=8'h40 and q=8'h81 (pre-shift value).
- Sync clear and counter: after 5 shifts, n_srclr=0 for one edge gives sr=0 and cnt=0. The next 8 shifts produce exactly one word_done pulse, after the 8th.
- Output enable: with st=8'hFF, n_oe=1 gives q='z. Returning n_oe to 0 gives 8'hFF with no clock edge needed. With the macro undefined, q tracks sr directly.
